// File: rtl/panel_load_sequencer_if.sv
// Word stream from the memory-image source into the panel load sequencer.
// Each transfer carries one (address, data) pair; word_last marks the final word.
interface panel_load_sequencer_if;
    logic        word_valid;
    logic [11:0] word_addr;
    logic [11:0] word_data;
    logic        word_last;
    logic        word_ready;

    // Image source side
    modport master (
        output word_valid, word_addr, word_data, word_last,
        input  word_ready
    );

    // Sequencer side
    modport slave (
        input  word_valid, word_addr, word_data, word_last,
        output word_ready
    );
endinterface

// File: rtl/panel_load_sequencer.sv
// Loads a PDP-8 memory image through the Front_Panel switch/button interface.
// For every word it sets the address, presses load-PC, sets the data and
// presses deposit, each with fixed setup/press/release timing. After the last
// word it loads START_PC and raises the run switch sw[12].
module panel_load_sequencer #(
    parameter int          HOLD_CYCLES   = 10,
    parameter int          SETTLE_CYCLES = 30,
    parameter logic [11:0] START_PC      = 12'o0200
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    panel_load_sequencer_if.slave         word,
    output logic [12:0]                   sw,
    output logic                          load_pc_btn,
    output logic                          deposit_btn,
    output logic                          busy,
    output logic                          running,
    output logic [12:0]                   words_loaded
);

    localparam int MAX_CYC = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [12:0]   WORDS_MAX   = 13'd4096;

    typedef enum logic [3:0] {
        IDLE, WAIT_WORD,
        LPC_SETUP, LPC_PRESS, LPC_RELEASE, SETTLE,
        DEP_SETUP, DEP_PRESS, DEP_RELEASE,
        FPC_SETUP, FPC_PRESS, FPC_RELEASE,
        RUNNING
    } state_t;

    state_t      state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [11:0] cap_data, cap_data_next;
    logic        cap_last, cap_last_next;
    logic [11:0] sw_lo_next;
    logic        run_next;
    logic [12:0] words_next;
    logic        timer_done;

    assign word.word_ready = (state == WAIT_WORD);
    assign timer_done      = (timer == '0);

    // Next-state, timer, capture and registered-output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_next    = state;
        timer_next    = timer_done ? timer : timer - 1'b1;
        cap_data_next = cap_data;
        cap_last_next = cap_last;
        sw_lo_next    = sw[11:0];
        run_next      = sw[12];
        words_next    = words_loaded;

        unique case (state)
            IDLE: if (start) begin
                state_next = WAIT_WORD;
                words_next = '0;
                run_next   = 1'b0;
            end
            WAIT_WORD: if (word.word_valid) begin
                state_next    = LPC_SETUP;
                timer_next    = HOLD_LOAD;
                sw_lo_next    = word.word_addr;
                cap_data_next = word.word_data;
                cap_last_next = word.word_last;
            end
            LPC_SETUP: if (timer_done) begin
                state_next = LPC_PRESS;
                timer_next = HOLD_LOAD;
            end
            LPC_PRESS: if (timer_done) begin
                state_next = LPC_RELEASE;
                timer_next = HOLD_LOAD;
            end
            LPC_RELEASE: if (timer_done) begin
                state_next = SETTLE;
                timer_next = SETTLE_LOAD;
            end
            SETTLE: if (timer_done) begin
                state_next = DEP_SETUP;
                timer_next = HOLD_LOAD;
                sw_lo_next = cap_data;
            end
            DEP_SETUP: if (timer_done) begin
                state_next = DEP_PRESS;
                timer_next = HOLD_LOAD;
            end
            DEP_PRESS: if (timer_done) begin
                state_next = DEP_RELEASE;
                timer_next = HOLD_LOAD;
            end
            DEP_RELEASE: if (timer_done) begin
                if (words_loaded != WORDS_MAX)
                    words_next = words_loaded + 13'd1;
                if (cap_last) begin
                    state_next = FPC_SETUP;
                    timer_next = HOLD_LOAD;
                    sw_lo_next = START_PC;
                end else begin
                    state_next = WAIT_WORD;
                end
            end
            FPC_SETUP: if (timer_done) begin
                state_next = FPC_PRESS;
                timer_next = HOLD_LOAD;
            end
            FPC_PRESS: if (timer_done) begin
                state_next = FPC_RELEASE;
                timer_next = HOLD_LOAD;
            end
            FPC_RELEASE: if (timer_done) begin
                state_next = RUNNING;
                run_next   = 1'b1;
            end
            RUNNING: ;
            default: state_next = IDLE;
        endcase

        // stop wins over everything: drop the word in flight, keep switches and count.
        if (stop) begin
            state_next = IDLE;
            timer_next = '0;
            run_next   = 1'b0;
            sw_lo_next = sw[11:0];
            words_next = words_loaded;
        end
    end

    // State, timer, capture and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            cap_data     <= '0;
            cap_last     <= 1'b0;
            sw           <= '0;
            load_pc_btn  <= 1'b0;
            deposit_btn  <= 1'b0;
            busy         <= 1'b0;
            running      <= 1'b0;
            words_loaded <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state        <= state_next;
            timer        <= timer_next;
            cap_data     <= cap_data_next;
            cap_last     <= cap_last_next;
            sw           <= {run_next, sw_lo_next};
            load_pc_btn  <= (state_next == LPC_PRESS) || (state_next == FPC_PRESS);
            deposit_btn  <= (state_next == DEP_PRESS);
            busy         <= (state_next != IDLE) && (state_next != RUNNING);
            running      <= (state_next == RUNNING);
            words_loaded <= words_next;
        end
    end

endmodule

// File: tb/tb_panel_load_sequencer.sv
// Directed bench for panel_load_sequencer: default timing instance plus a
// HOLD_CYCLES=1 / SETTLE_CYCLES=1 instance for the minimum-timing case.
module tb_panel_load_sequencer;

    localparam int          H        = 10;
    localparam int          S        = 30;
    localparam logic [11:0] START_PC = 12'o0200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-timing instance
    logic        start, stop;
    logic [12:0] sw;
    logic        lpc, dep, busy, running;
    logic [12:0] words;
    panel_load_sequencer_if w_if ();

    panel_load_sequencer #(.HOLD_CYCLES(H), .SETTLE_CYCLES(S), .START_PC(START_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .word         (w_if.slave),
        .sw           (sw),
        .load_pc_btn  (lpc),
        .deposit_btn  (dep),
        .busy         (busy),
        .running      (running),
        .words_loaded (words)
    );

    // Minimum-timing instance
    logic        f_start, f_stop;
    logic [12:0] f_sw;
    logic        f_lpc, f_dep, f_busy, f_running;
    logic [12:0] f_words;
    panel_load_sequencer_if f_if ();

    panel_load_sequencer #(.HOLD_CYCLES(1), .SETTLE_CYCLES(1), .START_PC(START_PC)) dut_fast (
        .clk          (clk),
        .rst          (rst),
        .start        (f_start),
        .stop         (f_stop),
        .word         (f_if.slave),
        .sw           (f_sw),
        .load_pc_btn  (f_lpc),
        .deposit_btn  (f_dep),
        .busy         (f_busy),
        .running      (f_running),
        .words_loaded (f_words)
    );

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Offer one word to the default instance and follow it until word_ready
    // returns (or RUNNING for the last word), checking every phase boundary.
    task automatic feed_word(input logic [11:0] a, input logic [11:0] d, input logic l,
                             input int exp_words);
        int n, lpc_first, lpc_cnt, lpc_bad, dep_first, dep_cnt, dep_bad;
        int fpc_first, fpc_cnt, fpc_bad, both, side_bad, exp_end;
        lpc_first = 0; lpc_cnt = 0; lpc_bad = 0;
        dep_first = 0; dep_cnt = 0; dep_bad = 0;
        fpc_first = 0; fpc_cnt = 0; fpc_bad = 0;
        both = 0; side_bad = 0;
        w_if.word_valid = 1'b1; w_if.word_addr = a; w_if.word_data = d; w_if.word_last = l;
        n = 0;
        while (w_if.word_ready !== 1'b1 && n < 500) begin tick(); n++; end
        total++;
        if (w_if.word_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout addr=%o: word_ready=%b required 1", a, w_if.word_ready);
            w_if.word_valid = 1'b0;
            return;
        end
        tick();
        // Scramble the bus after the accept edge so only captured values can appear.
        w_if.word_valid = 1'b0; w_if.word_addr = ~a; w_if.word_data = ~d; w_if.word_last = ~l;
        n = 1;
        while (w_if.word_ready !== 1'b1 && running !== 1'b1 && n < 400) begin
            if (lpc === 1'b1) begin
                if (dep_cnt == 0) begin
                    if (lpc_cnt == 0) lpc_first = n;
                    lpc_cnt++;
                    if (sw[11:0] !== a) lpc_bad++;
                end else begin
                    if (fpc_cnt == 0) fpc_first = n;
                    fpc_cnt++;
                    if (sw[11:0] !== START_PC) fpc_bad++;
                end
            end
            if (dep === 1'b1) begin
                if (dep_cnt == 0) dep_first = n;
                dep_cnt++;
                if (sw[11:0] !== d) dep_bad++;
            end
            if (lpc === 1'b1 && dep === 1'b1) both++;
            if (busy !== 1'b1 || sw[12] !== 1'b0) side_bad++;
            tick();
            n++;
        end
        exp_end = l ? (9*H + S + 1) : (6*H + S + 1);

        total++; if (lpc_first != H + 1) begin bad++; $display("FAIL lpc_first addr=%o: got %0d required %0d", a, lpc_first, H + 1); end
        total++; if (lpc_cnt != H) begin bad++; $display("FAIL lpc_len addr=%o: got %0d required %0d", a, lpc_cnt, H); end
        total++; if (lpc_bad != 0) begin bad++; $display("FAIL lpc_sw addr=%o: %0d cycles with wrong sw", a, lpc_bad); end
        total++; if (dep_first != 4*H + S + 1) begin bad++; $display("FAIL dep_first addr=%o: got %0d required %0d", a, dep_first, 4*H + S + 1); end
        total++; if (dep_cnt != H) begin bad++; $display("FAIL dep_len addr=%o: got %0d required %0d", a, dep_cnt, H); end
        total++; if (dep_bad != 0) begin bad++; $display("FAIL dep_sw addr=%o: %0d cycles with wrong sw", a, dep_bad); end
        total++; if (both != 0) begin bad++; $display("FAIL both_buttons addr=%o: %0d cycles both high, required 0", a, both); end
        total++; if (side_bad != 0) begin bad++; $display("FAIL busy_run addr=%o: %0d cycles busy!=1 or sw12!=0", a, side_bad); end
        total++; if (n != exp_end) begin bad++; $display("FAIL occupancy addr=%o: end cycle %0d required %0d", a, n, exp_end); end
        total++; if (words !== 13'(exp_words)) begin bad++; $display("FAIL words_loaded addr=%o: got %0d required %0d", a, words, exp_words); end
        if (l) begin
            total++; if (fpc_first != 7*H + S + 1) begin bad++; $display("FAIL fpc_first: got %0d required %0d", fpc_first, 7*H + S + 1); end
            total++; if (fpc_cnt != H) begin bad++; $display("FAIL fpc_len: got %0d required %0d", fpc_cnt, H); end
            total++; if (fpc_bad != 0) begin bad++; $display("FAIL fpc_sw: %0d cycles with wrong sw", fpc_bad); end
            total++; if (running !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL run_state: running=%b busy=%b required 1 0", running, busy); end
            total++; if (sw !== {1'b1, START_PC}) begin bad++; $display("FAIL run_sw: got %o required %o", sw, {1'b1, START_PC}); end
        end else begin
            total++; if (w_if.word_ready !== 1'b1) begin bad++; $display("FAIL ready_back addr=%o: got %b required 1", a, w_if.word_ready); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; f_start = 1'b0; f_stop = 1'b0;
        w_if.word_valid = 1'b0; w_if.word_addr = '0; w_if.word_data = '0; w_if.word_last = 1'b0;
        f_if.word_valid = 1'b0; f_if.word_addr = '0; f_if.word_data = '0; f_if.word_last = 1'b0;
        repeat (3) tick();
        total++;
        if ({sw, lpc, dep, busy, running, words, w_if.word_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: sw=%o lpc=%b dep=%b busy=%b run=%b words=%0d ready=%b required all 0",
                     sw, lpc, dep, busy, running, words, w_if.word_ready);
        end
        total++;
        if ({f_sw, f_lpc, f_dep, f_busy, f_running, f_words, f_if.word_ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs_fast: sw=%o lpc=%b dep=%b busy=%b required all 0", f_sw, f_lpc, f_dep, f_busy);
        end
        #2 rst = 1'b0;
        repeat (3) tick();
        total++; if (w_if.word_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_without_start: ready=%b busy=%b required 0 0", w_if.word_ready, busy); end
    endtask

    task automatic test_single_word();
        pulse_start();
        total++; if (w_if.word_ready !== 1'b1 || busy !== 1'b1 || words !== 13'd0) begin bad++; $display("FAIL start_enter: ready=%b busy=%b words=%0d required 1 1 0", w_if.word_ready, busy, words); end
        feed_word(12'o0200, 12'o7402, 1'b1, 1);
        pulse_stop();
        total++; if (running !== 1'b0 || sw !== {1'b0, START_PC} || words !== 13'd1) begin bad++; $display("FAIL stop_from_run: run=%b sw=%o words=%0d required 0 %o 1", running, sw, words, {1'b0, START_PC}); end
    endtask

    task automatic test_multi_word();
        int stall_bad;
        stall_bad = 0;
        pulse_start();
        feed_word(12'o0200, 12'o7200, 1'b0, 1);
        w_if.word_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (lpc !== 1'b0 || dep !== 1'b0 || w_if.word_ready !== 1'b1 || busy !== 1'b1) stall_bad++;
            tick();
        end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL stall: %0d cycles with activity, required 0", stall_bad); end
        feed_word(12'o0201, 12'o1205, 1'b0, 2);
        feed_word(12'o0202, 12'o7402, 1'b1, 3);
    endtask

    task automatic test_start_ignored_running();
        int leak;
        leak = 0;
        w_if.word_valid = 1'b1;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (w_if.word_ready !== 1'b0 || running !== 1'b1 || lpc !== 1'b0 || dep !== 1'b0 || words !== 13'd3) leak++;
            tick();
        end
        w_if.word_valid = 1'b0;
        total++; if (leak != 0) begin bad++; $display("FAIL running_ignores: %0d bad cycles, required 0", leak); end
        pulse_stop();
    endtask

    task automatic test_stop();
        int n;
        pulse_start();
        feed_word(12'o0200, 12'o7200, 1'b0, 1);
        w_if.word_valid = 1'b1; w_if.word_addr = 12'o0201; w_if.word_data = 12'o1205; w_if.word_last = 1'b0;
        tick();
        w_if.word_valid = 1'b0;
        n = 1;
        // A start pulse mid-word must not disturb the timing.
        while (dep !== 1'b1 && n < 200) begin
            start = (n == 40);
            tick();
            n++;
        end
        start = 1'b0;
        total++; if (n != 4*H + S + 1) begin bad++; $display("FAIL start_while_busy: deposit at %0d required %0d", n, 4*H + S + 1); end
        tick(); tick();
        pulse_stop();
        total++; if (dep !== 1'b0 || lpc !== 1'b0) begin bad++; $display("FAIL stop_buttons: dep=%b lpc=%b required 0 0", dep, lpc); end
        total++; if (busy !== 1'b0 || running !== 1'b0 || w_if.word_ready !== 1'b0) begin bad++; $display("FAIL stop_idle: busy=%b run=%b ready=%b required 0 0 0", busy, running, w_if.word_ready); end
        total++; if (words !== 13'd1) begin bad++; $display("FAIL stop_words: got %0d required 1", words); end
        total++; if (sw !== {1'b0, 12'o1205}) begin bad++; $display("FAIL stop_sw: got %o required %o", sw, {1'b0, 12'o1205}); end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        total++; if (w_if.word_ready !== 1'b0 || words !== 13'd1) begin bad++; $display("FAIL stop_priority: ready=%b words=%0d required 0 1", w_if.word_ready, words); end
        pulse_start();
        total++; if (w_if.word_ready !== 1'b1 || words !== 13'd0) begin bad++; $display("FAIL restart: ready=%b words=%0d required 1 0", w_if.word_ready, words); end
        pulse_stop();
    endtask

    task automatic test_async_reset();
        int n;
        pulse_start();
        w_if.word_valid = 1'b1; w_if.word_addr = 12'o0200; w_if.word_data = 12'o7402; w_if.word_last = 1'b1;
        tick();
        w_if.word_valid = 1'b0;
        n = 0;
        while (lpc !== 1'b1 && n < 100) begin tick(); n++; end
        total++; if (lpc !== 1'b1) begin bad++; $display("FAIL arst_setup: lpc=%b required 1", lpc); end
        tick(); tick();
        #3 rst = 1'b1;
        #1;
        total++;
        if ({sw, lpc, dep, busy, running, words, w_if.word_ready} !== '0) begin
            bad++;
            $display("FAIL arst_outputs: sw=%o lpc=%b dep=%b busy=%b run=%b words=%0d required all 0",
                     sw, lpc, dep, busy, running, words);
        end
        #2 rst = 1'b0;
        repeat (3) tick();
        total++; if (w_if.word_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL arst_needs_start: ready=%b busy=%b required 0 0", w_if.word_ready, busy); end
        pulse_start();
        total++; if (w_if.word_ready !== 1'b1) begin bad++; $display("FAIL arst_restart: ready=%b required 1", w_if.word_ready); end
        pulse_stop();
    endtask

    task automatic test_min_timing();
        logic [11:0] addrs [2];
        logic [11:0] datas [2];
        int n, lpc_first, lpc_last, lpc_cnt, dep_first, dep_cnt, both, exp_end;
        addrs[0] = 12'o0200; datas[0] = 12'o7200;
        addrs[1] = 12'o0201; datas[1] = 12'o7402;
        f_start = 1'b1; tick(); f_start = 1'b0;
        for (int w = 0; w < 2; w++) begin
            lpc_first = 0; lpc_last = 0; lpc_cnt = 0; dep_first = 0; dep_cnt = 0; both = 0;
            f_if.word_valid = 1'b1; f_if.word_addr = addrs[w]; f_if.word_data = datas[w]; f_if.word_last = (w == 1);
            n = 0;
            while (f_if.word_ready !== 1'b1 && n < 50) begin tick(); n++; end
            tick();
            f_if.word_valid = 1'b0;
            n = 1;
            while (f_if.word_ready !== 1'b1 && f_running !== 1'b1 && n < 50) begin
                if (f_lpc === 1'b1) begin if (lpc_cnt == 0) lpc_first = n; lpc_last = n; lpc_cnt++; end
                if (f_dep === 1'b1) begin if (dep_cnt == 0) dep_first = n; dep_cnt++; end
                if (f_lpc === 1'b1 && f_dep === 1'b1) both++;
                tick();
                n++;
            end
            exp_end = (w == 1) ? 11 : 8;
            total++; if (lpc_first != 2) begin bad++; $display("FAIL fast_lpc_first w%0d: got %0d required 2", w, lpc_first); end
            total++; if (lpc_cnt != w + 1) begin bad++; $display("FAIL fast_lpc_len w%0d: got %0d required %0d", w, lpc_cnt, w + 1); end
            total++; if (lpc_last != ((w == 1) ? 9 : 2)) begin bad++; $display("FAIL fast_lpc_last w%0d: got %0d required %0d", w, lpc_last, (w == 1) ? 9 : 2); end
            total++; if (dep_first != 6 || dep_cnt != 1) begin bad++; $display("FAIL fast_dep w%0d: first %0d len %0d required 6 1", w, dep_first, dep_cnt); end
            total++; if (both != 0) begin bad++; $display("FAIL fast_both w%0d: got %0d required 0", w, both); end
            total++; if (n != exp_end) begin bad++; $display("FAIL fast_occupancy w%0d: got %0d required %0d", w, n, exp_end); end
            total++; if (f_words !== 13'(w + 1)) begin bad++; $display("FAIL fast_words w%0d: got %0d required %0d", w, f_words, w + 1); end
        end
        total++; if (f_running !== 1'b1 || f_sw !== {1'b1, START_PC}) begin bad++; $display("FAIL fast_run: run=%b sw=%o required 1 %o", f_running, f_sw, {1'b1, START_PC}); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_word();
        test_start_ignored_running();
        test_stop();
        test_async_reset();
        test_min_timing();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
